// File: rtl/laplacian_3x3_stream.sv
// 3x3 Laplacian window stage: three row taps in, one filtered pixel per image pixel out.
// Latency: window loads on the accepting edge; dout/valid_out/border_out one edge later.
// Backpressure: in_ready drops for exactly one FLUSH cycle after each line's last column.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   valid_in / in_ready  pixel handshake; a pixel is taken when both are high
//   sof, mode            start of frame (column 0, row 0) and kernel select latched on sof
//   din1, din2, din3     row y-1, y, y+1 taps from the line buffer
//   dout, valid_out      filtered pixel and its one-cycle strobe
//   border_out           dout is a border pixel and was forced to zero
module laplacian_3x3_stream #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int OUT_ABS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof,
  input  logic              mode,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic              in_ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  output logic              border_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = DATA_W + 5;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic signed [AW-1:0] PIX_MAX = AW'((2 ** DATA_W) - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_mode;
  // Index 0/1/2 = rows y-1 / y / y+1; L, C, R = columns x-1, x, x+1.
  logic [DATA_W-1:0] r_l [3];
  logic [DATA_W-1:0] r_c [3];
  logic [DATA_W-1:0] r_r [3];
  logic              r_win_vld;
  logic [CW-1:0]     r_win_x;
  logic [RW-1:0]     r_win_y;

  logic              w_run;
  logic              w_acc;
  logic [CW-1:0]     w_col_eff;
  logic [RW-1:0]     w_row_eff;
  logic              w_first;
  logic              w_last;
  logic signed [AW-1:0] w_sum4;
  logic signed [AW-1:0] w_corner;
  logic signed [AW-1:0] w_lap;
  logic signed [AW-1:0] w_abs;
  logic [DATA_W-1:0] w_pix;
  logic              w_border;

  function automatic logic signed [AW-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({{(AW - DATA_W){1'b0}}, v});
  endfunction

  assign w_run = (r_state == S_RUN);
  assign w_acc = valid_in && w_run;
  // An accepted sof restarts the frame: this pixel is column 0 of row 0.
  assign w_col_eff = sof ? '0 : r_col;
  assign w_row_eff = sof ? '0 : r_row;
  assign w_first   = (w_col_eff == '0);
  assign w_last    = (w_col_eff == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_RUN: begin
        in_ready = 1'b1;
        if (w_acc && w_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= 1'b0;
      r_win_vld <= 1'b0;
      r_win_x   <= '0;
      r_win_y   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_l[i] <= '0;
        r_c[i] <= '0;
        r_r[i] <= '0;
      end
    end else begin
      r_win_vld <= 1'b0;
      if (w_acc) begin
        if (sof) r_mode <= mode;
        for (int i = 0; i < 3; i++) begin
          // Column 0 zero-loads L and C: left padding, and discards any abandoned line.
          r_l[i] <= w_first ? '0 : r_c[i];
          r_c[i] <= w_first ? '0 : r_r[i];
        end
        r_r[0] <= din1;
        r_r[1] <= din2;
        r_r[2] <= din3;
        // The last column holds col; the FLUSH cycle clears it.
        r_col  <= w_last ? w_col_eff : w_col_eff + CW'(1);
        r_row  <= w_row_eff;
        if (!w_first) begin
          r_win_vld <= 1'b1;
          r_win_x   <= w_col_eff - CW'(1);
          r_win_y   <= w_row_eff;
        end
      end else if (r_state == S_FLUSH) begin
        // Shift in zeros on the right to complete the last column's window.
        for (int i = 0; i < 3; i++) begin
          r_l[i] <= r_c[i];
          r_c[i] <= r_r[i];
          r_r[i] <= '0;
        end
        r_col     <= '0;
        r_row     <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        r_win_vld <= 1'b1;
        r_win_x   <= COL_LAST;
        r_win_y   <= r_row;
      end
    end
  end

  assign w_sum4   = ext(r_c[0]) + ext(r_c[2]) + ext(r_l[1]) + ext(r_r[1]);
  assign w_corner = ext(r_l[0]) + ext(r_r[0]) + ext(r_l[2]) + ext(r_r[2]);
  assign w_lap    = r_mode ? (ext(r_c[1]) <<< 3) - (w_sum4 + w_corner)
                           : (ext(r_c[1]) <<< 2) - w_sum4;
  assign w_border = (r_win_x == '0) || (r_win_x == COL_LAST) ||
                    (r_win_y == '0) || (r_win_y == ROW_LAST);

  always_comb begin
    w_abs = (w_lap < 0) ? -w_lap : w_lap;
    w_pix = '0;
    if (OUT_ABS != 0) begin
      if (w_abs > PIX_MAX) w_pix = '1;
      else                 w_pix = w_abs[DATA_W-1:0];
    end else begin
      if (w_lap < 0)            w_pix = '0;
      else if (w_lap > PIX_MAX) w_pix = '1;
      else                      w_pix = w_lap[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      valid_out  <= 1'b0;
      border_out <= 1'b0;
    end else begin
      valid_out <= r_win_vld;
      if (r_win_vld) begin
        border_out <= w_border;
        dout       <= w_border ? '0 : w_pix;
      end else begin
        border_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_laplacian_3x3_stream.sv
module tb_laplacian_3x3_stream;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic sof = 1'b0;
  logic mode = 1'b0;
  logic [DW-1:0] din1 = '0;
  logic [DW-1:0] din2 = '0;
  logic [DW-1:0] din3 = '0;
  logic rdy0, rdy1, vo0, vo1, bo0, bo1;
  logic [DW-1:0] do0, do1;

  always #5 clk = ~clk;

  laplacian_3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .OUT_ABS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .mode(mode),
    .din1(din1), .din2(din2), .din3(din3),
    .in_ready(rdy0), .dout(do0), .valid_out(vo0), .border_out(bo0));

  laplacian_3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .OUT_ABS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .mode(mode),
    .din1(din1), .din2(din2), .din3(din3),
    .in_ready(rdy1), .dout(do1), .valid_out(vo1), .border_out(bo1));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; int x; int y; int e0; int e1; int b;} exp_t;
  exp_t q[$];
  int t1[W], t2[W], t3[W];
  int m_col = 0, m_row = 0, m_mode = 0, flush_cyc = -10;
  int img[H][W];
  int cap0[H][W], cap1[H][W], capb[H][W];

  function automatic int tap(input int r, input int x);
    if (x < 0 || x >= W) return 0;
    case (r)
      1: return t1[x];
      2: return t2[x];
      default: return t3[x];
    endcase
  endfunction

  task automatic push_exp(input int x, input int due);
    exp_t e;
    int tot, v, mag;
    tot = 0;
    for (int r = 1; r <= 3; r++)
      for (int dx = -1; dx <= 1; dx++)
        if (m_mode != 0 || dx == 0 || r == 2) tot += tap(r, x + dx);
    // Kernel = n*centre - (sum of n neighbours) = (n+1)*centre - (sum incl. centre).
    v   = ((m_mode != 0) ? 9 : 5) * tap(2, x) - tot;
    mag = (v < 0) ? -v : v;
    e.b  = (x == 0 || x == W-1 || m_row == 0 || m_row == H-1) ? 1 : 0;
    e.e0 = (e.b != 0) ? 0 : ((v < 0) ? 0 : ((v > 255) ? 255 : v));
    e.e1 = (e.b != 0) ? 0 : ((mag > 255) ? 255 : mag);
    e.x = x; e.y = m_row; e.due = due;
    q.push_back(e);
  endtask

  task automatic model_accept(input int s, input int m, input int a, input int b, input int c, input int ac);
    if (s != 0) begin m_col = 0; m_row = 0; m_mode = m; end
    t1[m_col] = a; t2[m_col] = b; t3[m_col] = c;
    if (m_col >= 1) push_exp(m_col - 1, ac + 1);
    if (m_col == W-1) begin
      push_exp(W-1, ac + 2);
      flush_cyc = ac;
      m_col = 0;
      m_row = (m_row + 1) % H;
    end else begin
      m_col++;
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      chk("in_ready", int'(rdy0), (cyc == flush_cyc) ? 0 : 1);
      chk("in_ready_abs", int'(rdy1), (cyc == flush_cyc) ? 0 : 1);
      if (vo0 || vo1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_cycle", cyc, e.due);
          chk("valid_out", int'(vo0), 1);
          chk("valid_out_abs", int'(vo1), 1);
          chk("dout_clamp", int'(do0), e.e0);
          chk("dout_abs", int'(do1), e.e1);
          chk("border", int'(bo0), e.b);
          chk("border_abs", int'(bo1), e.b);
          cap0[e.y][e.x] = int'(do0);
          cap1[e.y][e.x] = int'(do1);
          capb[e.y][e.x] = int'(bo0);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_output", 0, 1);
        e = q.pop_front();
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      sof  = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      din1 = DW'($urandom);
      din2 = DW'($urandom);
      din3 = DW'($urandom);
    end
  endtask

  task automatic send(input int s, input int m, input int a, input int b, input int c);
    int g, ac;
    @(negedge clk);
    valid_in = 1'b1; sof = 1'(s); mode = 1'(m);
    din1 = DW'(a); din2 = DW'(b); din3 = DW'(c);
    g = 0;
    while (rdy0 !== 1'b1 && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (g >= 8) begin
      chk("accept_timeout", 0, 1);
      valid_in = 1'b0; sof = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ac = cyc;
    valid_in = 1'b0; sof = 1'b0;
    model_accept(s, m, a, b, c, ac);
  endtask

  // Sends full rows 0..rows-1, then columns 0..last_cols-1 of row `rows`.
  task automatic send_frame(input int md, input int gap_pct, input int rows, input int last_cols);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y > rows || (y == rows && x >= last_cols)) return;
        if (int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
        send((x == 0 && y == 0) ? 1 : 0,
             (x == 0 && y == 0) ? md : int'($urandom_range(0, 1)),
             (y > 0) ? img[y-1][x] : 0, img[y][x], (y < H-1) ? img[y+1][x] : 0);
      end
    end
  endtask

  task automatic fill_img(input int v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(0, 255));
  endtask

  task automatic clear_cap();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin cap0[y][x] = -1; cap1[y][x] = -1; capb[y][x] = -1; end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {int frame; int x; int y; int e0; int e1; int b;} vec_t;
  vec_t vt[18];

  task automatic check_vecs(input int f);
    for (int i = 0; i < 18; i++) begin
      if (vt[i].frame == f) begin
        chk($sformatf("vec%0d_clamp", i), cap0[vt[i].y][vt[i].x], vt[i].e0);
        chk($sformatf("vec%0d_abs", i), cap1[vt[i].y][vt[i].x], vt[i].e1);
        chk($sformatf("vec%0d_border", i), capb[vt[i].y][vt[i].x], vt[i].b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // flat 100, mode 0
    vt[0]  = '{1, 3, 1, 0, 0, 0};
    vt[1]  = '{1, 0, 1, 0, 0, 1};
    vt[2]  = '{1, 7, 2, 0, 0, 1};
    vt[3]  = '{1, 3, 0, 0, 0, 1};
    vt[4]  = '{1, 4, 3, 0, 0, 1};
    // single 200 at (3,2), mode 0
    vt[5]  = '{2, 3, 2, 255, 255, 0};
    vt[6]  = '{2, 2, 2, 0, 200, 0};
    vt[7]  = '{2, 4, 2, 0, 200, 0};
    vt[8]  = '{2, 3, 1, 0, 200, 0};
    vt[9]  = '{2, 3, 3, 0, 0, 1};
    vt[10] = '{2, 5, 1, 0, 0, 0};
    // mode 1 latched at sof, single 10 at (3,1)
    vt[11] = '{3, 3, 1, 80, 80, 0};
    vt[12] = '{3, 2, 1, 0, 10, 0};
    vt[13] = '{3, 3, 2, 0, 10, 0};
    vt[14] = '{3, 5, 1, 0, 0, 0};
    // mode 1, all 255 except 0 at (4,2)
    vt[15] = '{4, 4, 2, 0, 255, 0};
    vt[16] = '{4, 3, 1, 255, 255, 0};
    vt[17] = '{4, 1, 1, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(rdy0), 1);
    chk("rst_dout", int'(do0), 0);
    chk("rst_dout_abs", int'(do1), 0);
    chk("rst_valid_out", int'(vo0), 0);
    chk("rst_border", int'(bo0), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    fill_img(100); clear_cap();
    send_frame(0, 0, H, 0); idle(4); check_vecs(1);

    fill_img(0); img[2][3] = 200; clear_cap();
    send_frame(0, 0, H, 0); idle(4); check_vecs(2);

    fill_img(0); img[1][3] = 10; clear_cap();
    send_frame(1, 0, H, 0); idle(4); check_vecs(3);

    fill_img(255); img[2][4] = 0; clear_cap();
    send_frame(1, 25, H, 0); idle(4); check_vecs(4);

    // randomized frames, random gaps and held-valid through FLUSH
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      send_frame(int'($urandom_range(0, 1)), (k < 2) ? 0 : 30, H, 0);
    end
    idle(4);

    // sof arrives at column 5 of row 2: abandoned line
    fill_rand();
    send_frame(0, 20, 2, 5);
    fill_rand();
    send_frame(1, 0, H, 0);
    idle(4);

    // reset while in FLUSH
    fill_rand();
    send_frame(0, 0, 1, W);
    chk("flush_in_ready", int'(rdy0), 0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstflush_in_ready", int'(rdy0), 1);
    chk("rstflush_in_ready_abs", int'(rdy1), 1);
    chk("rstflush_valid_out", int'(vo0), 0);
    chk("rstflush_dout", int'(do0), 0);
    chk("rstflush_dout_abs", int'(do1), 0);
    chk("rstflush_border", int'(bo0), 0);
    q.delete();
    m_col = 0; m_row = 0; m_mode = 0; flush_cyc = -10;
    @(negedge clk);
    chk("rstflush_valid_hold", int'(vo0), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    fill_rand();
    send_frame(1, 30, H, 0);
    fill_rand();
    send_frame(0, 0, H, 0);

    idle(6);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
